// File: rtl/dp_sched.sv
// ---------------------------------------------------------------------------
// dp_sched
//
// Shares one four-operand sequential datapath among NREQ requesters.
// A round-robin arbiter picks a winner in IDLE, its mode and A..D operands
// are captured into the dp_* registers, the datapath gets a one-cycle clear
// pulse and then a one-cycle start pulse, and the scheduler waits for
// dp_done. The result is returned to the granted requester together with a
// one-cycle ack.
//
// Optional feature macro: DP_SCHED_TIMEOUT_EN
//   Defined     - WAIT is bounded by an 8-bit watchdog. After TIMEOUT WAIT
//                 cycles without dp_done the operation is aborted and acked
//                 with err=1 and rsp_data=0.
//   Not defined - WAIT waits for dp_done indefinitely and err is tied to 0.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand / result width
//   TIMEOUT  watchdog limit in WAIT cycles (1..255), watchdog build only
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset (0 = reset)
//   req[NREQ]                request levels, held until own ack
//   mode_in[NREQ]            per-requester mode bit
//   a_in..d_in[NREQ*W]       per-requester operands, requester i at [i*W +: W]
//   gnt[NREQ]                one-hot grant, high from grant through RESP
//   ack[NREQ]                one-cycle completion pulse
//   rsp_data[W]              result, valid while any ack bit is high
//   err                      high with ack when the operation timed out
//   busy                     high in every state except IDLE
//   dp_clr                   one-cycle datapath clear pulse
//   dp_start, dp_mode        datapath start pulse / mode
//   dp_a..dp_d[W]            datapath operands
//   dp_result[W], dp_done    datapath result and done level
// ---------------------------------------------------------------------------
module dp_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   mode_in,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ*W-1:0] c_in,
    input  logic [NREQ*W-1:0] d_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      rsp_data,
    output logic              err,
    output logic              busy,
    output logic              dp_clr,
    output logic              dp_start,
    output logic              dp_mode,
    output logic [W-1:0]      dp_a,
    output logic [W-1:0]      dp_b,
    output logic [W-1:0]      dp_c,
    output logic [W-1:0]      dp_d,
    input  logic [W-1:0]      dp_result,
    input  logic              dp_done
);

    // Elaboration-time parameter range checks.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("dp_sched: NREQ must be in 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dp_sched: TIMEOUT must be in 1..255");
    end

    localparam int LW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [W-1:0]    rsp_q, rsp_d;
    logic            busy_q, busy_d;
    logic            clr_q, clr_d;
    logic            start_q, start_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    c_q, c_d;
    logic [W-1:0]    d_q, d_d;

    // Arbitration results.
    logic            found_s;
    logic [LW-1:0]   win_s;
    logic [NREQ-1:0] win_oh_s;

`ifdef DP_SCHED_TIMEOUT_EN
    // The counter holds the number of WAIT cycles already completed, so the
    // abort fires on the edge that ends WAIT cycle number TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;
`endif

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = {LW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (!found_s && req[idx]) begin
                found_s = 1'b1;
                win_s   = LW'(idx);
            end else begin
                found_s = found_s;
            end
        end
        win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    end

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = {NREQ{1'b0}};
        rsp_d   = rsp_q;
        busy_d  = busy_q;
        clr_d   = 1'b0;
        start_d = 1'b0;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
`ifdef DP_SCHED_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    // Operands are captured here so later changes on the
                    // requester side cannot disturb the running operation.
                    state_d = S_CLEAR;
                    last_d  = win_s;
                    gnt_d   = win_oh_s;
                    busy_d  = 1'b1;
                    clr_d   = 1'b1;
                    mode_d  = mode_in[win_s];
                    a_d     = a_in[win_s*W +: W];
                    b_d     = b_in[win_s*W +: W];
                    c_d     = c_in[win_s*W +: W];
                    d_d     = d_in[win_s*W +: W];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_LAUNCH;
                start_d = 1'b1;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef DP_SCHED_TIMEOUT_EN
                wcnt_d  = 8'd0;
`endif
            end
            S_WAIT: begin
                // A done arriving on the same edge as the timeout wins.
                if (dp_done) begin
                    state_d = S_RESP;
                    rsp_d   = dp_result;
                    ack_d   = gnt_q;
                end else begin
`ifdef DP_SCHED_TIMEOUT_EN
                    if (wcnt_q == TO_LAST) begin
                        state_d = S_RESP;
                        rsp_d   = {W{1'b0}};
                        ack_d   = gnt_q;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = {NREQ{1'b0}};
                rsp_d   = {W{1'b0}};
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = {NREQ{1'b0}};
                rsp_d   = {W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= LW'(NREQ - 1);
            gnt_q   <= {NREQ{1'b0}};
            ack_q   <= {NREQ{1'b0}};
            rsp_q   <= {W{1'b0}};
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            c_q     <= {W{1'b0}};
            d_q     <= {W{1'b0}};
`ifdef DP_SCHED_TIMEOUT_EN
            wcnt_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
`ifdef DP_SCHED_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign rsp_data = rsp_q;
    assign busy     = busy_q;
    assign dp_clr   = clr_q;
    assign dp_start = start_q;
    assign dp_mode  = mode_q;
    assign dp_a     = a_q;
    assign dp_b     = b_q;
    assign dp_c     = c_q;
    assign dp_d     = d_q;
`ifdef DP_SCHED_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dp_sched.sv
// ---------------------------------------------------------------------------
// tb_dp_sched
//
// Drives dp_sched against a behavioural datapath: after a start pulse done
// rises three cycles later with A+B+C+D (mode 0) or A+B-C-D (mode 1) mod
// 2^W; a clear pulse drops done. A table of single operations, directed
// multi-cycle sequences and a randomized phase scored against a
// transaction-level round-robin model.
// ---------------------------------------------------------------------------
module tb_dp_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TO   = 5;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   mode_in;
    logic [NREQ*W-1:0] a_in, b_in, c_in, d_in;
    logic [NREQ-1:0]   gnt, ack;
    logic [W-1:0]      rsp_data;
    logic              err, busy, dp_clr, dp_start, dp_mode;
    logic [W-1:0]      dp_a, dp_b, dp_c, dp_d;
    logic [W-1:0]      dp_result;
    logic              dp_done;

    dp_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .mode_in(mode_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .gnt(gnt), .ack(ack), .rsp_data(rsp_data), .err(err), .busy(busy),
        .dp_clr(dp_clr), .dp_start(dp_start), .dp_mode(dp_mode),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_result(dp_result), .dp_done(dp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath.
    logic never_done;
    int   cd;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_done <= 1'b0; cd <= 0; dp_result <= '0;
        end else if (dp_clr) begin
            dp_done <= 1'b0; cd <= 0;
        end else if (dp_start) begin
            cd <= 2;
            dp_result <= dp_mode ? W'(dp_a + dp_b - dp_c - dp_d)
                                 : W'(dp_a + dp_b + dp_c + dp_d);
        end else if (cd == 1) begin
            cd <= 0; dp_done <= !never_done;
        end else if (cd > 1) begin
            cd <= cd - 1;
        end
    end

    // Pulse counters (cycles each signal was high).
    int clr_cnt, start_cnt, ack_cyc;
    always @(posedge clk) begin
        if (dp_clr)   clr_cnt++;
        if (dp_start) start_cnt++;
        if (ack != 0) ack_cyc++;
    end

    logic [52:0] allout;
    assign allout = {gnt, ack, rsp_data, err, busy, dp_clr, dp_start, dp_mode,
                     dp_a, dp_b, dp_c, dp_d};

    int total = 0;
    int bad   = 0;
    int exp_last;
    logic       om [NREQ];
    logic [7:0] oa [NREQ], ob [NREQ], oc [NREQ], od [NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] calc(input logic m, input logic [7:0] a, b, c, d);
        return m ? 8'(a + b - c - d) : 8'(a + b + c + d);
    endfunction

    // Next requester in round-robin order after 'last'; -1 if none.
    function automatic int next_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic m, input logic [7:0] a, b, c, d);
        om[i] = m; oa[i] = a; ob[i] = b; oc[i] = c; od[i] = d;
        mode_in[i] = m;
        a_in[i*W +: W] = a; b_in[i*W +: W] = b;
        c_in[i*W +: W] = c; d_in[i*W +: W] = d;
    endtask

    task automatic wait_ack(input int bound, output int cyc, output logic ok);
        cyc = 0; ok = 1'b0;
        while (cyc < bound && !ok) begin
            @(negedge clk);
            cyc++;
            if (ack != 0) ok = 1'b1;
        end
    endtask

    // One isolated operation with full timing checks.
    task automatic op_single(input int i, input logic m, input logic [7:0] a, b, c, d,
                             input logic [7:0] e, input string nm);
        int cyc; logic ok; logic [NREQ-1:0] oh;
        oh = 4'b0001 << i;
        @(negedge clk);
        set_ops(i, m, a, b, c, d);
        req[i] = 1'b1;
        clr_cnt = 0; start_cnt = 0; ack_cyc = 0;
        @(negedge clk);
        chk({nm, "_grant"}, {gnt, busy, dp_clr, dp_start}, {oh, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        chk({nm, "_launch"}, {dp_clr, dp_start, dp_mode, dp_a, dp_b, dp_c, dp_d},
            {1'b0, 1'b1, m, a, b, c, d});
        wait_ack(40, cyc, ok);
        chk({nm, "_ack_seen"}, ok, 1'b1);
        chk({nm, "_latency"}, cyc, 4);
        chk({nm, "_ack"}, ack, oh);
        chk({nm, "_rsp"}, rsp_data, e);
        chk({nm, "_err"}, err, 1'b0);
        req[i] = 1'b0;
        @(negedge clk);
        chk({nm, "_after"}, {gnt, ack, rsp_data, busy}, 0);
        chk({nm, "_pulses"}, {8'(clr_cnt), 8'(start_cnt), 8'(ack_cyc)}, 24'h010101);
        exp_last = i;
    endtask

    typedef struct {
        int         idx;
        logic       m;
        logic [7:0] a, b, c, d;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int cyc; logic ok; logic flag; int w;
        reset = 1'b0; req = '0; mode_in = '0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0;
        never_done = 1'b0; exp_last = NREQ - 1;
        clr_cnt = 0; start_cnt = 0; ack_cyc = 0;

        tbl[0] = '{0, 1'b0, 8'h01, 8'h02, 8'hFF, 8'hFE, 8'h00};
        tbl[1] = '{1, 1'b0, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        tbl[2] = '{2, 1'b1, 8'hFE, 8'h01, 8'h01, 8'h04, 8'hFA};
        tbl[3] = '{3, 1'b1, 8'h05, 8'h03, 8'h10, 8'h01, 8'hF7};
        tbl[4] = '{0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
        tbl[5] = '{3, 1'b0, 8'h80, 8'h80, 8'h7F, 8'h00, 8'h7F};

        repeat (3) @(negedge clk);
        chk("reset_outputs", allout, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", allout, 0);

        // Table of isolated operations.
        for (int t = 0; t < 6; t++) begin
            op_single(tbl[t].idx, tbl[t].m, tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].d,
                      tbl[t].e, $sformatf("tbl%0d", t));
        end

        // All four requesting and held: 0,1,2,3 then 0 again.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            set_ops(i, 1'(i % 2), 8'(8'h11 * (i + 1)), 8'(i + 3), 8'h05, 8'(i));
        req = 4'b1111;
        ack_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            w = next_winner(req, exp_last);
            wait_ack(60, cyc, ok);
            chk($sformatf("rr%0d_seen", k), ok, 1'b1);
            chk($sformatf("rr%0d_ack", k), ack, 4'b0001 << w);
            chk($sformatf("rr%0d_rsp", k), rsp_data, calc(om[w], oa[w], ob[w], oc[w], od[w]));
            exp_last = w;
            if (k == 4) req = '0;
            @(negedge clk);
            chk($sformatf("rr%0d_idle_gap", k), {busy, ack}, 0);
        end
        chk("rr_ack_cycles", ack_cyc, 5);

        // Requester 2 drops req and changes a_in one cycle after grant.
        @(negedge clk);
        set_ops(2, 1'b1, 8'hFE, 8'h01, 8'h01, 8'h04);
        req = 4'b0100;
        cyc = 0;
        while (cyc < 10 && gnt == 0) begin @(negedge clk); cyc++; end
        chk("drop_gnt", gnt, 4'b0100);
        @(negedge clk);
        req[2] = 1'b0;
        a_in[2*W +: W] = 8'h00;
        wait_ack(40, cyc, ok);
        chk("drop_ack", ack, 4'b0100);
        chk("drop_rsp", rsp_data, 8'hFA);
        exp_last = 2;
        @(negedge clk);

        // Datapath never finishes.
        never_done = 1'b1;
        @(negedge clk);
        set_ops(0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01);
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
`ifdef DP_SCHED_TIMEOUT_EN
        wait_ack(40, cyc, ok);
        chk("to_latency", cyc, 6);
        chk("to_resp", {ack, err, rsp_data}, {4'b0001, 1'b1, 8'h00});
        req = '0;
        exp_last = 0;
        @(negedge clk);
        chk("to_after", {err, busy, ack}, 0);
        never_done = 1'b0;
`else
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack != 0 || err != 1'b0 || busy != 1'b1) flag = 1'b1;
        end
        chk("stuck_wait", flag, 1'b0);
        #2 reset = 1'b0;
        #1 chk("stuck_reset", allout, 0);
        @(negedge clk);
        req = '0;
        never_done = 1'b0;
        reset = 1'b1;
        exp_last = NREQ - 1;
`endif

        // Reset in WAIT aborts with no ack and restarts the pointer.
        @(negedge clk);
        set_ops(1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        req = 4'b0010;
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", {gnt, busy}, {4'b0010, 1'b1});
        #2 reset = 1'b0;
        #1 chk("rst_async_outputs", allout, 0);
        flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (allout != 0) flag = 1'b1;
        end
        chk("rst_held_quiet", flag, 1'b0);
        reset = 1'b1;
        exp_last = NREQ - 1;
        set_ops(2, 1'b1, 8'h40, 8'h02, 8'h01, 8'h01);
        req = 4'b0110;
        @(negedge clk);
        chk("rst_first_gnt", gnt, 4'b0010);
        wait_ack(40, cyc, ok);
        chk("rst_ack1", {ack, rsp_data}, {4'b0010, 8'hAA});
        req[1] = 1'b0;
        wait_ack(40, cyc, ok);
        chk("rst_ack2", {ack, rsp_data}, {4'b0100, 8'h40});
        req[2] = 1'b0;
        exp_last = 2;
        @(negedge clk);

        // Randomized traffic against the round-robin transaction model.
        begin
            int in_op = 0; int w_exp = 0; logic [7:0] r_exp = '0;
            int ops = 0; int busy_run = 0; int jack;
            for (int c = 0; c < 4000; c++) begin
                if (c >= 1500 && req == 0 && !busy && in_op == 0) break;
                @(negedge clk);
                jack = -1;
                if (gnt != 0 && in_op == 0) begin
                    in_op = 1;
                    w_exp = next_winner(req, exp_last);
                    chk("rnd_gnt", gnt, 4'b0001 << w_exp);
                    if (w_exp < 0) w_exp = 0;
                    r_exp = calc(om[w_exp], oa[w_exp], ob[w_exp], oc[w_exp], od[w_exp]);
                end
                if (ack != 0) begin
                    if (in_op == 0) begin
                        chk("rnd_spurious_ack", ack, 0);
                    end else begin
                        chk("rnd_ack", {ack, rsp_data, err}, {4'b0001 << w_exp, r_exp, 1'b0});
                        exp_last = w_exp;
                        req[w_exp] = 1'b0;
                        jack = w_exp;
                        in_op = 0;
                        ops++;
                    end
                end
                busy_run = busy ? busy_run + 1 : 0;
                if (busy_run > 30) begin
                    chk("rnd_busy_bound", busy_run, 30);
                    break;
                end
                if (c < 1500) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (!req[i] && i != jack && $urandom_range(0, 3) == 0) begin
                            set_ops(i, 1'($urandom), 8'($urandom), 8'($urandom),
                                    8'($urandom), 8'($urandom));
                            req[i] = 1'b1;
                        end
                    end
                end
            end
            chk("rnd_drained", {req, busy}, 0);
            chk("rnd_ops", (ops >= 20), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
